// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, parity
// selectors, line levels and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // data_xor is the reduction XOR of the data word; odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        logic bit_s;
        if (par_typ == PAR_ODD) begin
            bit_s = ~data_xor;
        end else begin
            bit_s = data_xor;
        end
        return bit_s;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer: state register, MSB-first bit counter and busy flag.
// Exposes next-state values so the datapath can register the line level.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter  int width = 8,
    localparam int CNT_W = (width > 1) ? $clog2(width) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic             par_en,
    output logic             accept,
    output tx_state_e        state_d,
    output logic [CNT_W-1:0] cnt_d,
    output logic             busy
);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Next-state and bit-counter decode; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                    cnt_d   = CNT_W'(width - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    if (par_en) begin
                        state_d = PARITY;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and busy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: word/parity latch, parity generation and the
// registered serial line, sequenced by uart_tx_fsm.
module uart_tx
    import uart_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic             TX_OUT,
    output logic             busy
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

    logic             accept_s;
    tx_state_e        state_d_s;
    logic [CNT_W-1:0] cnt_d_s;

    logic [width-1:0] data_q;
    logic [width-1:0] data_d;
    logic             par_en_q;
    logic             par_en_d;
    logic             par_typ_q;
    logic             par_typ_d;
    logic             tx_q;
    logic             tx_d;

    uart_tx_fsm #(
        .width (width)
    ) u_fsm (
        .clk        (CLK),
        .rst        (RST),
        .data_valid (DATA_VALID),
        .par_en     (par_en_q),
        .accept     (accept_s),
        .state_d    (state_d_s),
        .cnt_d      (cnt_d_s),
        .busy       (busy)
    );

    // Latch the word and frame options only on acceptance; the line level is
    // decoded from the values the state registers are about to take.
    always_comb begin
        if (accept_s) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
        end else begin
            data_d    = data_q;
            par_en_d  = par_en_q;
            par_typ_d = par_typ_q;
        end
        case (state_d_s)
            IDLE:    tx_d = IDLE_LVL;
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_d[cnt_d_s];
            PARITY:  tx_d = parity_bit(^data_d, par_typ_d);
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LVL;
        endcase
    end

    // Datapath registers; reset clears the latch and forces the line high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q    <= {width{1'b0}};
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            tx_q      <= IDLE_LVL;
        end else begin
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
        end
    end

    assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (width=8) with hand-computed
// frames in line order.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(.width(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Strobe one word and compare the whole frame plus the following idle cycle.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input logic [10:0] bits, input int len);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s tx bit%0d", tag, k), TX_OUT, bits[len-1-k]);
            check($sformatf("%s busy bit%0d", tag, k), busy, 1'b1);
            tick();
        end
        check($sformatf("%s idle tx", tag), TX_OUT, 1'b1);
        check($sformatf("%s idle busy", tag), busy, 1'b0);
    endtask

    logic [10:0] exp_bits;

    initial begin
        // Reset state
        RST = 1'b1;
        tick();
        tick();
        check("reset tx", TX_OUT, 1'b1);
        check("reset busy", busy, 1'b0);
        RST = 1'b0;
        tick();
        check("post-reset idle tx", TX_OUT, 1'b1);
        check("post-reset idle busy", busy, 1'b0);

        // Even parity 0xF0: 0,11110000,0,1
        send_frame("even_f0", 8'hF0, 1'b1, 1'b0, 11'b0_11110000_0_1, 11);
        tick();

        // Odd parity 0xAA: 0,10101010,1,1
        send_frame("odd_aa", 8'hAA, 1'b1, 1'b1, 11'b0_10101010_1_1, 11);
        tick();

        // No parity 0xAA (PAR_TYP ignored): 0,10101010,1
        send_frame("nopar_aa", 8'hAA, 1'b0, 1'b1, 11'b0_0_10101010_1, 10);

        // Back-to-back: strobe in the idle cycle right after the stop bit
        send_frame("b2b_e7", 8'hE7, 1'b1, 1'b0, 11'b0_11100111_0_1, 11);
        send_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 11'b0_0_10101010_1, 10);
        tick();

        // Mid-frame strobe and input changes: frame 0x3C even stays 0,00111100,0,1
        exp_bits   = 11'b0_00111100_0_1;
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        for (int k = 0; k < 11; k++) begin
            check($sformatf("midvalid tx bit%0d", k), TX_OUT, exp_bits[10-k]);
            check($sformatf("midvalid busy bit%0d", k), busy, 1'b1);
            if (k == 3) begin
                P_DATA     = 8'hFF;
                PAR_TYP    = 1'b1;
                PAR_EN     = 1'b0;
                DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = 1'b0;
            end
            tick();
        end
        DATA_VALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("midvalid no-extra tx %0d", k), TX_OUT, 1'b1);
            check($sformatf("midvalid no-extra busy %0d", k), busy, 1'b0);
            tick();
        end

        // Reset during DATA aborts the frame; line high right after the edge
        exp_bits   = 11'b0_01010101_0_1;
        P_DATA     = 8'h55;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("abort tx bit%0d", k), TX_OUT, exp_bits[10-k]);
            tick();
        end
        RST = 1'b1;
        tick();
        check("abort reset tx", TX_OUT, 1'b1);
        check("abort reset busy", busy, 1'b0);
        RST = 1'b0;
        tick();
        check("abort idle tx", TX_OUT, 1'b1);
        check("abort idle busy", busy, 1'b0);

        // Fresh frame after the abort: 0x0F odd -> 0,00001111,1,1
        send_frame("after_rst_0f", 8'h0F, 1'b1, 1'b1, 11'b0_00001111_1_1, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
